// File: rtl/cfs_algn_ctrl.sv
// cfs_algn_ctrl: re-packs RX FIFO entries into transfers of the configured
// size and byte offset for the TX FIFO. A 2*B-byte accumulator sits between
// the two FIFOs so that a pop and a push can both complete in the same cycle.
module cfs_algn_ctrl #(
  parameter  int unsigned ALGN_DATA_WIDTH   = 32,
  localparam int unsigned ALGN_BYTES        = ALGN_DATA_WIDTH / 8,
  localparam int unsigned ALGN_OFFSET_WIDTH = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(ALGN_BYTES),
  localparam int unsigned ALGN_SIZE_WIDTH   = $clog2(ALGN_BYTES) + 1,
  localparam int unsigned FIFO_DATA_WIDTH   = ALGN_DATA_WIDTH + ALGN_OFFSET_WIDTH + ALGN_SIZE_WIDTH
) (
  input  logic                         pclk,
  input  logic                         preset,
  input  logic [ALGN_OFFSET_WIDTH-1:0] ctrl_offset,
  input  logic [ALGN_SIZE_WIDTH-1:0]   ctrl_size,
  input  logic                         pop_valid,
  input  logic [FIFO_DATA_WIDTH-1:0]   pop_data,
  output logic                         pop_ready,
  output logic                         push_valid,
  output logic [FIFO_DATA_WIDTH-1:0]   push_data,
  input  logic                         push_ready,
  output logic                         busy
);

  localparam int unsigned ACC_BYTES = 2 * ALGN_BYTES;
  localparam int unsigned CNT_WIDTH = $clog2(ACC_BYTES) + 1;

  // Accumulator (index 0 is the oldest byte), fill level and latched config
  logic [7:0]                   r_buf [ACC_BYTES];
  logic [CNT_WIDTH-1:0]         r_cnt;
  logic [ALGN_SIZE_WIDTH-1:0]   r_cfg_size;
  logic [ALGN_OFFSET_WIDTH-1:0] r_cfg_offset;

  logic [ALGN_DATA_WIDTH-1:0]   w_pop_dat;
  logic [ALGN_OFFSET_WIDTH-1:0] w_pop_off;
  logic [ALGN_SIZE_WIDTH-1:0]   w_pop_size;
  logic [ALGN_SIZE_WIDTH-1:0]   w_lanes_left;
  logic [ALGN_SIZE_WIDTH-1:0]   w_take;
  logic                         w_pop_hs;
  logic                         w_push_hs;
  logic [CNT_WIDTH-1:0]         w_pushed;
  logic [CNT_WIDTH-1:0]         w_base;
  logic [CNT_WIDTH-1:0]         w_cnt_nxt;
  logic [7:0]                   w_pop_bytes [ALGN_BYTES];
  logic [7:0]                   w_buf_nxt [ACC_BYTES];
  logic [ALGN_DATA_WIDTH-1:0]   w_push_lanes;
  logic                         w_ctrl_bad;
  logic [ALGN_SIZE_WIDTH-1:0]   w_cfg_size_nxt;
  logic [ALGN_OFFSET_WIDTH-1:0] w_cfg_offset_nxt;

  // Entry fields: {size, offset, data}
  assign w_pop_dat  = pop_data[ALGN_DATA_WIDTH-1:0];
  assign w_pop_off  = pop_data[ALGN_DATA_WIDTH +: ALGN_OFFSET_WIDTH];
  assign w_pop_size = pop_data[FIFO_DATA_WIDTH-1 -: ALGN_SIZE_WIDTH];

  // A malformed entry that runs past the top lane is truncated there
  assign w_lanes_left = ALGN_SIZE_WIDTH'(ALGN_BYTES - 32'(w_pop_off));
  assign w_take       = (w_pop_size > w_lanes_left) ? w_lanes_left : w_pop_size;

  // Handshakes and fill-level arithmetic
  assign pop_ready  = (r_cnt <= CNT_WIDTH'(ALGN_BYTES)) && !preset;
  assign push_valid = (r_cnt >= CNT_WIDTH'(r_cfg_size));
  assign busy       = (r_cnt != '0);
  assign w_pop_hs   = pop_valid && pop_ready;
  assign w_push_hs  = push_valid && push_ready;
  assign w_pushed   = w_push_hs ? CNT_WIDTH'(r_cfg_size) : '0;
  assign w_base     = r_cnt - w_pushed;
  assign w_cnt_nxt  = w_base + (w_pop_hs ? CNT_WIDTH'(w_take) : '0);

  // Illegal sizes fall back to a full-width, lane-0 transfer
  assign w_ctrl_bad       = (ctrl_size == '0) || (ctrl_size > ALGN_SIZE_WIDTH'(ALGN_BYTES));
  assign w_cfg_size_nxt   = w_ctrl_bad ? ALGN_SIZE_WIDTH'(ALGN_BYTES) : ctrl_size;
  assign w_cfg_offset_nxt = w_ctrl_bad ? '0 : ctrl_offset;

  // Pick entry bytes starting at the entry's offset lane
  always_comb begin
    for (int i = 0; i < int'(ALGN_BYTES); i++) begin
      w_pop_bytes[i] = '0;
      for (int l = 0; l < int'(ALGN_BYTES); l++) begin
        if (32'(w_pop_off) + 32'(i) == 32'(l)) w_pop_bytes[i] = w_pop_dat[l*8 +: 8];
      end
    end
  end

  // Next accumulator: drop pushed bytes, then append popped bytes after the survivors
  always_comb begin
    for (int j = 0; j < int'(ACC_BYTES); j++) begin
      w_buf_nxt[j] = r_buf[j];
      if (w_push_hs) begin
        w_buf_nxt[j] = '0;
        for (int k = 0; k < int'(ACC_BYTES); k++) begin
          if (32'(k) == 32'(j) + 32'(r_cfg_size)) w_buf_nxt[j] = r_buf[k];
        end
      end
      if (w_pop_hs) begin
        for (int i = 0; i < int'(ALGN_BYTES); i++) begin
          if ((32'(i) < 32'(w_take)) && (32'(j) == 32'(w_base) + 32'(i))) begin
            w_buf_nxt[j] = w_pop_bytes[i];
          end
        end
      end
    end
  end

  // Outgoing lanes: buf[i] lands on lane cfg_offset+i, everything else zero
  always_comb begin
    w_push_lanes = '0;
    for (int l = 0; l < int'(ALGN_BYTES); l++) begin
      for (int i = 0; i < int'(ALGN_BYTES); i++) begin
        if ((32'(i) < 32'(r_cfg_size)) && (32'(r_cfg_offset) + 32'(i) == 32'(l))) begin
          w_push_lanes[l*8 +: 8] = r_buf[i];
        end
      end
    end
  end

  assign push_data = {r_cfg_size, r_cfg_offset, w_push_lanes};

  // State update; config only follows ctrl while the accumulator is empty
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_cnt        <= '0;
      r_cfg_size   <= ALGN_SIZE_WIDTH'(ALGN_BYTES);
      r_cfg_offset <= '0;
      for (int j = 0; j < int'(ACC_BYTES); j++) r_buf[j] <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      for (int j = 0; j < int'(ACC_BYTES); j++) r_buf[j] <= w_buf_nxt[j];
      if (r_cnt == '0) begin
        r_cfg_size   <= w_cfg_size_nxt;
        r_cfg_offset <= w_cfg_offset_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cfs_algn_ctrl.sv
// Directed bench for cfs_algn_ctrl at the default 32-bit width (B=4).
module tb_cfs_algn_ctrl;

  logic        pclk;
  logic        preset;
  logic [1:0]  ctrl_offset;
  logic [2:0]  ctrl_size;
  logic        pop_valid;
  logic [36:0] pop_data;
  logic        pop_ready;
  logic        push_valid;
  logic [36:0] push_data;
  logic        push_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  cfs_algn_ctrl #(.ALGN_DATA_WIDTH(32)) dut (
    .pclk        (pclk),
    .preset      (preset),
    .ctrl_offset (ctrl_offset),
    .ctrl_size   (ctrl_size),
    .pop_valid   (pop_valid),
    .pop_data    (pop_data),
    .pop_ready   (pop_ready),
    .push_valid  (push_valid),
    .push_data   (push_data),
    .push_ready  (push_ready),
    .busy        (busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic logic [36:0] pk(input logic [2:0] s, input logic [1:0] o, input logic [31:0] d);
    return {s, o, d};
  endfunction

  task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    preset      = 1'b1;
    ctrl_size   = 3'd4;
    ctrl_offset = 2'd0;
    pop_valid   = 1'b0;
    pop_data    = '0;
    push_ready  = 1'b0;
    #1;
    chk("rst_pop_ready_comb", 37'(pop_ready), 37'd0);
    tick();
    tick();
    chk("rst_push_valid", 37'(push_valid), 37'd0);
    chk("rst_busy", 37'(busy), 37'd0);
    chk("rst_pop_ready", 37'(pop_ready), 37'd0);
    preset = 1'b0;
    #1;
    chk("post_rst_pop_ready", 37'(pop_ready), 37'd1);

    // Full-word pass-through
    push_ready = 1'b1;
    pop_valid  = 1'b1;
    pop_data   = pk(3'd4, 2'd0, 32'h44332211);
    tick();
    pop_valid = 1'b0;
    chk("pass_push_valid", 37'(push_valid), 37'd1);
    chk("pass_push_data", push_data, pk(3'd4, 2'd0, 32'h44332211));
    chk("pass_busy", 37'(busy), 37'd1);
    tick();
    chk("pass_busy_after", 37'(busy), 37'd0);
    chk("pass_valid_after", 37'(push_valid), 37'd0);

    // Split one word into two half-words at lane 2
    push_ready  = 1'b0;
    ctrl_size   = 3'd2;
    ctrl_offset = 2'd2;
    tick();
    pop_valid = 1'b1;
    pop_data  = pk(3'd4, 2'd0, 32'hDDCCBBAA);
    tick();
    pop_valid = 1'b0;
    chk("split_push_data0", push_data, pk(3'd2, 2'd2, 32'hBBAA0000));
    push_ready = 1'b1;
    tick();
    chk("split_push_valid1", 37'(push_valid), 37'd1);
    chk("split_push_data1", push_data, pk(3'd2, 2'd2, 32'hDDCC0000));
    tick();
    chk("split_busy_after", 37'(busy), 37'd0);

    // Merge four single bytes from different lanes into one word
    push_ready  = 1'b0;
    ctrl_size   = 3'd4;
    ctrl_offset = 2'd0;
    tick();
    pop_valid = 1'b1;
    pop_data  = pk(3'd1, 2'd3, 32'h11000000);
    tick();
    pop_data = pk(3'd1, 2'd2, 32'h00220000);
    tick();
    pop_data = pk(3'd1, 2'd1, 32'h00003300);
    tick();
    chk("merge_partial_valid", 37'(push_valid), 37'd0);
    chk("merge_partial_busy", 37'(busy), 37'd1);
    pop_data = pk(3'd1, 2'd0, 32'h00000044);
    tick();
    pop_valid = 1'b0;
    chk("merge_push_valid", 37'(push_valid), 37'd1);
    chk("merge_push_data", push_data, pk(3'd4, 2'd0, 32'h44332211));
    push_ready = 1'b1;
    tick();
    chk("merge_busy_after", 37'(busy), 37'd0);

    // Backpressure while words keep arriving
    push_ready = 1'b0;
    pop_valid  = 1'b1;
    pop_data   = pk(3'd4, 2'd0, 32'h03020100);
    tick();
    chk("bp_pop_ready_cnt4", 37'(pop_ready), 37'd1);
    chk("bp_data_c1", push_data, pk(3'd4, 2'd0, 32'h03020100));
    pop_data = pk(3'd4, 2'd0, 32'h07060504);
    tick();
    chk("bp_pop_ready_cnt8", 37'(pop_ready), 37'd0);
    chk("bp_data_c2", push_data, pk(3'd4, 2'd0, 32'h03020100));
    pop_data = pk(3'd4, 2'd0, 32'h0B0A0908);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("bp_pop_ready_hold", 37'(pop_ready), 37'd0);
      chk("bp_data_stable", push_data, pk(3'd4, 2'd0, 32'h03020100));
    end
    push_ready = 1'b1;
    tick();
    chk("bp_resume_data", push_data, pk(3'd4, 2'd0, 32'h07060504));
    chk("bp_resume_pop_ready", 37'(pop_ready), 37'd1);
    tick();
    pop_valid = 1'b0;
    chk("bp_simul_data", push_data, pk(3'd4, 2'd0, 32'h0B0A0908));
    chk("bp_simul_valid", 37'(push_valid), 37'd1);
    tick();
    chk("bp_busy_after", 37'(busy), 37'd0);

    // Config held while non-empty, then reset mid-accumulation
    push_ready = 1'b0;
    tick();
    pop_valid = 1'b1;
    pop_data  = pk(3'd3, 2'd0, 32'h00332211);
    tick();
    pop_valid = 1'b0;
    chk("hold_valid_cnt3", 37'(push_valid), 37'd0);
    ctrl_size = 3'd2;
    tick();
    chk("hold_cfg_ignored1", 37'(push_valid), 37'd0);
    tick();
    chk("hold_cfg_ignored2", 37'(push_valid), 37'd0);
    chk("hold_busy", 37'(busy), 37'd1);
    preset = 1'b1;
    #1;
    chk("mid_rst_pop_ready", 37'(pop_ready), 37'd0);
    tick();
    chk("mid_rst_busy", 37'(busy), 37'd0);
    chk("mid_rst_valid", 37'(push_valid), 37'd0);
    preset = 1'b0;
    #1;
    chk("mid_rst_pop_ready_rel", 37'(pop_ready), 37'd1);
    tick();
    pop_valid = 1'b1;
    pop_data  = pk(3'd1, 2'd0, 32'h000000AA);
    tick();
    chk("after_rst_one_byte", 37'(push_valid), 37'd0);
    pop_data = pk(3'd1, 2'd1, 32'h0000BB00);
    tick();
    pop_valid = 1'b0;
    chk("after_rst_valid", 37'(push_valid), 37'd1);
    chk("after_rst_data", push_data, pk(3'd2, 2'd0, 32'h0000BBAA));
    push_ready = 1'b1;
    tick();
    chk("after_rst_busy", 37'(busy), 37'd0);

    // Illegal ctrl size falls back to full word at lane 0
    push_ready  = 1'b0;
    ctrl_size   = 3'd0;
    ctrl_offset = 2'd3;
    tick();
    pop_valid = 1'b1;
    pop_data  = pk(3'd4, 2'd0, 32'hCAFEBABE);
    tick();
    pop_valid = 1'b0;
    chk("size0_data", push_data, pk(3'd4, 2'd0, 32'hCAFEBABE));
    push_ready = 1'b1;
    tick();
    chk("size0_busy", 37'(busy), 37'd0);

    // Single byte moved to the top lane
    push_ready  = 1'b0;
    ctrl_size   = 3'd1;
    ctrl_offset = 2'd3;
    tick();
    pop_valid = 1'b1;
    pop_data  = pk(3'd1, 2'd0, 32'h0000005A);
    tick();
    pop_valid = 1'b0;
    chk("lane3_data", push_data, pk(3'd1, 2'd3, 32'h5A000000));
    push_ready = 1'b1;
    tick();
    chk("lane3_busy", 37'(busy), 37'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfs_algn_ctrl.md
CFS_ALGN_CTRL -- requirements
Module: cfs_algn_ctrl

Interface
REQ-001 SHALL have parameter ALGN_DATA_WIDTH, default 32, MD data width in bits; B = ALGN_DATA_WIDTH/8 bytes per word.
REQ-002 SHALL have localparams ALGN_OFFSET_WIDTH (1 if ALGN_DATA_WIDTH<=8, else clog2(B)), ALGN_SIZE_WIDTH (clog2(B)+1), FIFO_DATA_WIDTH (sum of data, offset and size widths).
REQ-003 SHALL have one clock and a synchronous, active-high reset: pclk rising edge; preset resets all state.
REQ-004 pclk  input  1  clock.
REQ-005 preset  input  1  synchronous active-high reset.
REQ-006 ctrl_offset  input  ALGN_OFFSET_WIDTH  CTRL.OFFSET, output byte lane.
REQ-007 ctrl_size  input  ALGN_SIZE_WIDTH  CTRL.SIZE, output bytes per transfer.
REQ-008 pop_valid  input  1  RX FIFO entry available.
REQ-009 pop_data  input  FIFO_DATA_WIDTH  RX FIFO entry {size, offset, data}, size in MSBs, data in LSBs.
REQ-010 pop_ready  output  1  entry consumed on pop_valid&pop_ready.
REQ-011 push_valid  output  1  aligned transfer available to TX FIFO.
REQ-012 push_data  output  FIFO_DATA_WIDTH  aligned transfer {size, offset, data}, same packing as pop_data.
REQ-013 push_ready  input  1  TX FIFO accepts on push_valid&push_ready.
REQ-014 busy  output  1  accumulator non-empty.

Function
REQ-015 SHALL hold a 2*B-byte accumulator buf[0..2B-1] and byte count cnt (0..2B).
REQ-016 Bytes taken from an RX entry SHALL be data bytes [offset .. offset+size-1], lane offset first.
REQ-017 pop_ready SHALL be 1 when cnt <= B and preset is 0, else 0; it SHALL NOT depend on pop_data or push_ready.
REQ-018 Latched config cfg_size/cfg_offset SHALL load from ctrl_size/ctrl_offset on every cycle with cnt==0; while cnt!=0 they SHALL hold.
REQ-019 ctrl_size==0 or ctrl_size>B SHALL latch as cfg_size=B, cfg_offset=0.
REQ-020 push_valid SHALL be 1 exactly when cnt >= cfg_size (registered state only, no combinational path from pop inputs).
REQ-021 push_data SHALL carry size=cfg_size, offset=cfg_offset, data lane cfg_offset+i = buf[i] for i<cfg_size, all other lanes 0.
REQ-022 While push_valid=1 and push_ready=0, push_data SHALL be stable.
REQ-023 On push handshake, buf SHALL shift down by cfg_size bytes and cnt SHALL decrease by cfg_size.
REQ-024 On pop handshake, the entry's bytes SHALL be written at buf[cnt - pushed] where pushed = cfg_size if push handshake in same cycle, else 0; cnt_next = cnt - pushed + entry size.
REQ-025 Simultaneous pop and push SHALL both complete in one cycle without byte loss or reordering.
REQ-026 Latency: a pop completing cnt>=cfg_size SHALL raise push_valid the next cycle.
REQ-027 Unused buf bytes (index >= cnt) SHALL be don't-care internally but never appear in push_data.
REQ-028 busy SHALL equal (cnt != 0).
REQ-029 Derived states: EMPTY (cnt==0), ACCUM (0<cnt<cfg_size), READY (cnt>=cfg_size); no other sequencing state.

Reset
REQ-030 With preset=1 at a pclk edge: cnt=0, buf cleared, cfg_size=B, cfg_offset=0; after that edge push_valid=0, busy=0; pop_ready=0 while preset=1.
REQ-031 Reset mid-operation SHALL discard accumulated bytes; no partial transfer is emitted afterward.

Verification
REQ-032 B=4, ctrl size=4 off=0; pop {4,0,0x44332211} -> next cycle push {4,0,0x44332211}, busy=0 after push.
REQ-033 ctrl size=2 off=2; pop {4,0,0xDDCCBBAA} -> pushes {2,2,0xBBAA0000} then {2,2,0xDDCC0000}.
REQ-034 ctrl size=4; pops {1,3,0x11000000},{1,2,0x00220000},{1,1,0x00003300},{1,0,0x00000044} -> one push {4,0,0x44332211}.
REQ-035 push_ready=0 for 6 cycles with pops streaming size 4 -> push_data stable, pop_ready=0 once cnt=8, resumes after push_ready=1.
REQ-036 cnt=3 at ctrl size=4, change ctrl_size to 2 -> ignored until cnt returns to 0; preset asserted at cnt=3 -> busy=0, push_valid=0 next cycle.
